display_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the digital clock's 4-digit display. It cycles a 2-bit digit index into the 2-to-4 digit decoder and presents the matching BCD digit to the segment path. A blanking interval between digits prevents ghosting. Digit values are captured once per frame into shadow registers, so a displayed frame never mixes old and new time values.

---
 rtl/display_scan_ctrl_if.sv | 21 ++
 rtl/display_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_display_scan_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_ctrl_if.sv
// Bundle of the scan controller's enable/data inputs and its digit-drive outputs.
// The master side feeds digits and enable; the slave side is the scan controller.
interface display_scan_ctrl_if;
   logic        en;
   logic [15:0] digits;
   logic [3:0]  blank;
   logic [1:0]  sel;
   logic [3:0]  an;
   logic [3:0]  bcd;
   logic        frame;

   modport master (
      output en, digits, blank,
      input  sel, an, bcd, frame
   );

   modport slave (
      input  en, digits, blank,
      output sel, an, bcd, frame
   );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for the 4-digit clock display.
// Each digit slot is a blanking interval followed by a show interval.
// Digits and blank mask are snapshotted once per frame so a frame never mixes
// old and new values. Every output is a register.
module display_scan_ctrl #(
   parameter int SHOW_CYC  = 1000,
   parameter int BLANK_CYC = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   display_scan_ctrl_if.slave  bus
);

   localparam int MAX_CYC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
   localparam bit HAS_BLANK = (BLANK_CYC > 0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [1:0]       sel, sel_n, sel_inc;
   logic [3:0]       an, an_n;
   logic [3:0]       bcd, bcd_n;
   logic             frame, frame_n;
   logic [15:0]      sdig, sdig_n;
   logic [3:0]       sblank, sblank_n;

   function automatic logic [3:0] digit_of(input logic [15:0] v, input logic [1:0] i);
      return v[{i, 2'b00} +: 4];
   endfunction

   function automatic logic [3:0] decode(input logic [1:0] i);
      return 4'b0001 << i;
   endfunction

   // Next-state and next-output logic; en low in a scanning state always wins and parks in IDLE.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      sel_n    = sel;
      an_n     = an;
      bcd_n    = bcd;
      frame_n  = 1'b0;
      sdig_n   = sdig;
      sblank_n = sblank;
      sel_inc  = sel + 2'd1;

      if (state != IDLE && !bus.en) begin
         state_n = IDLE;
         an_n    = '0;
         sel_n   = 2'd0;
         cnt_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               an_n = '0;
               if (bus.en) begin
                  sdig_n   = bus.digits;
                  sblank_n = bus.blank;
                  frame_n  = 1'b1;
                  sel_n    = 2'd0;
                  bcd_n    = bus.digits[3:0];
                  cnt_n    = '0;
                  if (HAS_BLANK) begin
                     state_n = BLANK;
                  end else begin
                     state_n = SHOW;
                     an_n    = bus.blank[0] ? 4'b0000 : 4'b0001;
                  end
               end
            end
            BLANK: begin
               if (cnt == BLANK_LAST) begin
                  state_n = SHOW;
                  cnt_n   = '0;
                  an_n    = sblank[sel] ? 4'b0000 : decode(sel);
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
            SHOW: begin
               if (cnt == SHOW_LAST) begin
                  sel_n = sel_inc;
                  cnt_n = '0;
                  if (sel == 2'd3) begin
                     sdig_n   = bus.digits;
                     sblank_n = bus.blank;
                     frame_n  = 1'b1;
                  end
                  bcd_n   = digit_of(sdig_n, sel_inc);
                  state_n = HAS_BLANK ? BLANK : SHOW;
                  an_n    = (HAS_BLANK || sblank_n[sel_inc]) ? 4'b0000 : decode(sel_inc);
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
            default: begin
               state_n = IDLE;
               an_n    = '0;
            end
         endcase
      end
   end

   // State, counter, shadows and registered outputs; reset clears everything without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         sel    <= 2'd0;
         an     <= 4'd0;
         bcd    <= 4'd0;
         frame  <= 1'b0;
         sdig   <= 16'd0;
         sblank <= 4'd0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         sel    <= sel_n;
         an     <= an_n;
         bcd    <= bcd_n;
         frame  <= frame_n;
         sdig   <= sdig_n;
         sblank <= sblank_n;
      end
   end

   assign bus.sel   = sel;
   assign bus.an    = an;
   assign bus.bcd   = bcd;
   assign bus.frame = frame;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Testbench for display_scan_ctrl: two instances (with and without blanking)
// share one randomized stimulus stream. A frame-position reference model
// predicts outputs into per-instance queues; a monitor pops and compares.
module tb_display_scan_ctrl;

   localparam int SHOW_CYC = 4;
   localparam int BCYC0    = 2;
   localparam int BCYC1    = 0;

   typedef struct packed {
      logic [1:0] sel;
      logic [3:0] an;
      logic [3:0] bcd;
      logic       frame;
   } exp_t;

   typedef struct {
      bit          running;
      int          t;
      logic [15:0] sd;
      logic [3:0]  sb;
      logic [3:0]  bcd;
   } mstate_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   mstate_t ms [2];
   exp_t    q0 [$];
   exp_t    q1 [$];

   display_scan_ctrl_if bus0 ();
   display_scan_ctrl_if bus1 ();

   display_scan_ctrl #(.SHOW_CYC(SHOW_CYC), .BLANK_CYC(BCYC0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   display_scan_ctrl #(.SHOW_CYC(SHOW_CYC), .BLANK_CYC(BCYC1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input exp_t act, input exp_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s t=%0t got sel=%0d an=%b bcd=%0h frame=%b, expected sel=%0d an=%b bcd=%0h frame=%b",
                  name, $time, act.sel, act.an, act.bcd, act.frame,
                  exp.sel, exp.an, exp.bcd, exp.frame);
      end
   endtask

   function automatic void modelReset(input int k);
      ms[k].running = 1'b0;
      ms[k].t       = 0;
      ms[k].sd      = '0;
      ms[k].sb      = '0;
      ms[k].bcd     = '0;
   endfunction

   // Reference model: position within the frame determines digit, blanking and enable.
   function automatic exp_t modelStep(input int k, input logic rstLow, input logic enV,
                                      input logic [15:0] d, input logic [3:0] b);
      exp_t e;
      int   blankCyc, slot, p, dig, w;
      blankCyc = (k == 0) ? BCYC0 : BCYC1;
      slot     = blankCyc + SHOW_CYC;
      e        = '0;
      if (rstLow) begin
         modelReset(k);
         return e;
      end
      if (!ms[k].running) begin
         if (!enV) begin
            e.bcd = ms[k].bcd;
            return e;
         end
         ms[k].running = 1'b1;
         ms[k].t       = 0;
         ms[k].sd      = d;
         ms[k].sb      = b;
         e.frame       = 1'b1;
      end else if (!enV) begin
         ms[k].running = 1'b0;
         e.bcd         = ms[k].bcd;
         return e;
      end else begin
         ms[k].t++;
         if (ms[k].t % (4 * slot) == 0) begin
            ms[k].sd = d;
            ms[k].sb = b;
            e.frame  = 1'b1;
         end
      end
      p         = ms[k].t % (4 * slot);
      dig       = p / slot;
      w         = p % slot;
      e.sel     = 2'(dig);
      e.bcd     = ms[k].sd[dig*4 +: 4];
      ms[k].bcd = e.bcd;
      e.an      = (w >= blankCyc && !ms[k].sb[dig]) ? 4'(1 << dig) : 4'b0000;
      return e;
   endfunction

   // Drive one cycle of inputs at the falling edge and queue the prediction for the next rising edge.
   task automatic applyStimulus(input logic rstLow, input logic pulseRst, input logic enV,
                                input logic [15:0] d, input logic [3:0] b);
      @(negedge clk);
      if (pulseRst) begin
         rst_n = 1'b0;
         #1;
         checkOutput("async_rst_blank2", {bus0.sel, bus0.an, bus0.bcd, bus0.frame}, '0);
         checkOutput("async_rst_blank0", {bus1.sel, bus1.an, bus1.bcd, bus1.frame}, '0);
         #1;
         modelReset(0);
         modelReset(1);
      end
      rst_n       = !rstLow;
      bus0.en     = enV;
      bus0.digits = d;
      bus0.blank  = b;
      bus1.en     = enV;
      bus1.digits = d;
      bus1.blank  = b;
      q0.push_back(modelStep(0, rstLow, enV, d, b));
      q1.push_back(modelStep(1, rstLow, enV, d, b));
   endtask

   // Monitor: after each rising edge compare what each instance presents against the queued prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0) begin
            e = q0.pop_front();
            checkOutput("scan_blank2", {bus0.sel, bus0.an, bus0.bcd, bus0.frame}, e);
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            checkOutput("scan_blank0", {bus1.sel, bus1.an, bus1.bcd, bus1.frame}, e);
         end
      end
   end

   // Stimulus sequence: reset, normal scan, mid-frame update, blank mask, disable, random, async reset.
   initial begin
      int guard;
      checks      = 0;
      failures    = 0;
      rst_n       = 1'b0;
      bus0.en     = 1'b1;
      bus0.digits = 16'h1234;
      bus0.blank  = 4'h0;
      bus1.en     = 1'b1;
      bus1.digits = 16'h1234;
      bus1.blank  = 4'h0;
      modelReset(0);
      modelReset(1);

      repeat (3)  applyStimulus(1'b1, 1'b0, 1'b1, 16'h1234, 4'h0);
      repeat (34) applyStimulus(1'b0, 1'b0, 1'b1, 16'h1234, 4'h0);
      repeat (30) applyStimulus(1'b0, 1'b0, 1'b1, 16'h5678, 4'h0);
      repeat (30) applyStimulus(1'b0, 1'b0, 1'b1, 16'h5678, 4'b0100);

      guard = 0;
      while (!(ms[0].running && (ms[0].t % 24) == 14) && guard < 100) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 16'h9abc, 4'h0);
         guard++;
      end
      checks++;
      if (guard >= 100) begin
         failures++;
         $display("[TB] FAIL disable_setup could not reach sel=2 show slot, got %0d cycles, required <100", guard);
      end
      repeat (3)  applyStimulus(1'b0, 1'b0, 1'b0, 16'h9abc, 4'h0);
      repeat (30) applyStimulus(1'b0, 1'b0, 1'b1, 16'h4321, 4'h0);

      for (int i = 0; i < 400; i++) begin
         logic        enR;
         logic [15:0] dR;
         logic [3:0]  bR;
         logic        pR;
         enR = ($urandom_range(0, 99) != 0);
         dR  = 16'($urandom);
         bR  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         pR  = ($urandom_range(0, 199) == 0);
         applyStimulus(1'b0, pR, enR, dR, bR);
      end

      repeat (9)  applyStimulus(1'b0, 1'b0, 1'b1, 16'h0817, 4'h0);
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h2468, 4'h0);
      repeat (30) applyStimulus(1'b0, 1'b0, 1'b1, 16'h2468, 4'h0);

      guard = 0;
      while ((q0.size() != 0 || q1.size() != 0) && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      #2;
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain pending=%0d/%0d required 0/0", q0.size(), q1.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at t=%0t, required completion before 200000", $time);
      $fatal(1, "[TB] watchdog");
   end

endmodule
